// File: rtl/mul_slot_arbiter.sv
// Shares one 64x64 multiplier between two issue slots: round-robin grant, operands
// held for MUL_CYCLES so the product settles, then the selected half is captured.

module multiplier64bit (
   input  logic [63:0]  a,
   input  logic [63:0]  b,
   output logic [127:0] product
);
   // Full-width unsigned product; synthesis builds the CSA tree and final adder.
   assign product = {64'd0, a} * {64'd0, b};
endmodule

module mul_slot_arbiter #(
   parameter int MUL_CYCLES = 2,
   parameter int TAG_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [63:0]      a0,
   input  logic [63:0]      b0,
   input  logic [63:0]      a1,
   input  logic [63:0]      b1,
   input  logic             hi0,
   input  logic             hi1,
   input  logic [TAG_W-1:0] tag0,
   input  logic [TAG_W-1:0] tag1,
   input  logic             flush,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             res_valid,
   output logic [63:0]      res_data,
   output logic             res_id,
   output logic [TAG_W-1:0] res_tag
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       cnt;
   logic             prio;
   logic [63:0]      op_a;
   logic [63:0]      op_b;
   logic             op_hi;
   logic             op_id;
   logic [TAG_W-1:0] op_tag;
   logic [127:0]     product;
   logic             accept;
   logic             load_res;

   // Operand registers are the only multiplier inputs: a multicycle path of MUL_CYCLES.
   multiplier64bit u_mul (
      .a       (op_a),
      .b       (op_b),
      .product (product)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      load_res  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!flush) begin
               if (req0 && req1) begin
                  gnt0 = !prio;
                  gnt1 = prio;
               end else begin
                  gnt0 = req0;
                  gnt1 = req1;
               end
               if (req0 || req1) state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush) begin
               state_nxt = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_nxt = S_DONE;
               load_res  = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign accept    = gnt0 | gnt1;
   assign busy      = (state != S_IDLE);
   assign res_valid = (state == S_DONE) && !flush;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: operand and result registers are reset as well, so the multiplier never sees X after reset.
         state    <= S_IDLE;
         cnt      <= 4'd0;
         prio     <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_hi    <= 1'b0;
         op_id    <= 1'b0;
         op_tag   <= '0;
         res_data <= '0;
         res_id   <= 1'b0;
         res_tag  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_a   <= gnt1 ? a1 : a0;
            op_b   <= gnt1 ? b1 : b0;
            op_hi  <= gnt1 ? hi1 : hi0;
            op_tag <= gnt1 ? tag1 : tag0;
            op_id  <= gnt1;
            cnt    <= CNT_INIT;
            prio   <= gnt0;
         end else if (state == S_BUSY && !flush && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (load_res) begin
            res_data <= op_hi ? product[127:64] : product[63:0];
            res_id   <= op_id;
            res_tag  <= op_tag;
         end
      end
   end
endmodule

// File: tb/tb_mul_slot_arbiter.sv
// Drives three arbiters (MUL_CYCLES = 1, 2, 4) from shared inputs and checks each
// against a timestamp-based reference model every cycle, plus literal expectations.

module tb_mul_slot_arbiter;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0, req1;
   logic [63:0]      a0, b0, a1, b1;
   logic             hi0, hi1;
   logic [TAG_W-1:0] tag0, tag1;
   logic             flush;

   logic [2:0] gnt0_all, gnt1_all, busy_all, rv_all;

   int   total = 0;
   int   bad   = 0;
   int   ecnt  = 0;
   logic model_ok = 1'b0;

   int gcyc[$];
   int gslot[$];
   int rid[$];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Exact 128-bit product built from 32-bit limbs.
   function automatic logic [127:0] prod128(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] al, ah, bl, bh;
      al = {96'd0, a[31:0]};
      ah = {96'd0, a[63:32]};
      bl = {96'd0, b[31:0]};
      bh = {96'd0, b[63:32]};
      return ((ah * bh) << 64) + ((ah * bl + al * bh) << 32) + (al * bl);
   endfunction

   function automatic logic [63:0] half(input logic [63:0] a, input logic [63:0] b, input logic hi);
      logic [127:0] p;
      p = prod128(a, b);
      return hi ? p[127:64] : p[63:0];
   endfunction

   // Expected idle grants {gnt1, gnt0}.
   function automatic logic [1:0] arb(input logic r0, input logic r1, input logic fl, input logic pr);
      if (fl) return 2'b00;
      if (r0 && r1) return pr ? 2'b10 : 2'b01;
      return {r1, r0};
   endfunction

   function automatic logic [63:0] r64();
      case ($urandom_range(7))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'd1 << $urandom_range(63);
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   always @(posedge clk) ecnt <= ecnt + 1;
   always @(posedge clk) if (rst) model_ok <= 1'b1;

   for (genvar k = 0; k < 3; k++) begin : g_inst
      localparam int MC = (k == 0) ? 1 : (k == 1) ? 2 : 4;

      logic             gnt0, gnt1, busy, res_valid, res_id;
      logic [63:0]      res_data;
      logic [TAG_W-1:0] res_tag;

      mul_slot_arbiter #(.MUL_CYCLES(MC), .TAG_W(TAG_W)) dut (
         .clk       (clk),
         .rst       (rst),
         .req0      (req0),
         .req1      (req1),
         .a0        (a0),
         .b0        (b0),
         .a1        (a1),
         .b1        (b1),
         .hi0       (hi0),
         .hi1       (hi1),
         .tag0      (tag0),
         .tag1      (tag1),
         .flush     (flush),
         .gnt0      (gnt0),
         .gnt1      (gnt1),
         .busy      (busy),
         .res_valid (res_valid),
         .res_data  (res_data),
         .res_id    (res_id),
         .res_tag   (res_tag)
      );

      assign gnt0_all[k] = gnt0;
      assign gnt1_all[k] = gnt1;
      assign busy_all[k] = busy;
      assign rv_all[k]   = res_valid;

      // Model: an accepted op at edge t produces its result at edge t+MC and frees at t+MC+1.
      logic             m_active, m_prio, m_hi, m_id, m_rid;
      int               m_tacc;
      logic [63:0]      m_a, m_b, m_rdata;
      logic [TAG_W-1:0] m_tag, m_rtag;
      logic [1:0]       m_gnt;

      assign m_gnt = arb(req0, req1, flush, m_prio);

      always @(posedge clk) begin
         if (rst) begin
            m_active <= 1'b0;
            m_prio   <= 1'b0;
            m_rdata  <= '0;
            m_rid    <= 1'b0;
            m_rtag   <= '0;
         end else if (m_active) begin
            if (flush && (ecnt + 1 <= m_tacc + MC)) begin
               m_active <= 1'b0;
            end else if (ecnt + 1 == m_tacc + MC) begin
               m_rdata <= half(m_a, m_b, m_hi);
               m_rid   <= m_id;
               m_rtag  <= m_tag;
            end else if (ecnt + 1 == m_tacc + MC + 1) begin
               m_active <= 1'b0;
            end
         end else if (m_gnt != 2'b00) begin
            m_active <= 1'b1;
            m_tacc   <= ecnt + 1;
            m_id     <= m_gnt[1];
            m_a      <= m_gnt[1] ? a1 : a0;
            m_b      <= m_gnt[1] ? b1 : b0;
            m_hi     <= m_gnt[1] ? hi1 : hi0;
            m_tag    <= m_gnt[1] ? tag1 : tag0;
            m_prio   <= m_gnt[0];
         end
      end

      always @(negedge clk) begin
         if (model_ok) begin
            check($sformatf("mc%0d_gnt0", MC), gnt0, m_active ? 1'b0 : m_gnt[0]);
            check($sformatf("mc%0d_gnt1", MC), gnt1, m_active ? 1'b0 : m_gnt[1]);
            check($sformatf("mc%0d_busy", MC), busy, m_active);
            check($sformatf("mc%0d_res_valid", MC), res_valid,
                  m_active && (ecnt == m_tacc + MC) && !flush);
            check($sformatf("mc%0d_res_data", MC), res_data, m_rdata);
            check($sformatf("mc%0d_res_id", MC), res_id, m_rid);
            check($sformatf("mc%0d_res_tag", MC), res_tag, m_rtag);
         end
      end
   end

   task automatic drive_slot(input logic slot, input logic [63:0] a, input logic [63:0] b,
                             input logic hi, input logic [TAG_W-1:0] tag);
      if (slot) begin
         a1 = a; b1 = b; hi1 = hi; tag1 = tag; req1 = 1'b1;
      end else begin
         a0 = a; b0 = b; hi0 = hi; tag0 = tag; req0 = 1'b1;
      end
   endtask

   // One op with all instances idle; checks grant, per-instance latency and the MC=2 result.
   task automatic run_op(input logic slot, input logic [63:0] a, input logic [63:0] b,
                         input logic hi, input logic [TAG_W-1:0] tag, input logic [63:0] exp_data);
      int               lat [3];
      logic [63:0]      got_data;
      logic             got_id;
      logic [TAG_W-1:0] got_tag;
      lat      = '{-1, -1, -1};
      got_data = '0;
      got_id   = ~slot;
      got_tag  = ~tag;
      @(posedge clk); #1;
      drive_slot(slot, a, b, hi, tag);
      @(negedge clk);
      check("op_grant", slot ? gnt1_all : gnt0_all, 3'b111);
      @(posedge clk); #1;
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            if (rv_all[k] && lat[k] < 0) lat[k] = i;
         if (rv_all[1]) begin
            got_data = g_inst[1].res_data;
            got_id   = g_inst[1].res_id;
            got_tag  = g_inst[1].res_tag;
         end
         if (i == 2) check("op_busy_done", busy_all[1], 1'b1);
         if (i == 3) check("op_busy_drop", busy_all[1], 1'b0);
      end
      check("op_lat_mc1", lat[0], 1);
      check("op_lat_mc2", lat[1], 2);
      check("op_lat_mc4", lat[2], 4);
      check("op_data", got_data, exp_data);
      check("op_id", got_id, slot);
      check("op_tag", got_tag, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] seen;
      int         nres;
      int         cyc;

      rst = 1'b1; flush = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      hi0 = 1'b0; hi1 = 1'b0; tag0 = '0; tag1 = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy_all, 3'b000);
      check("rst_valid", rv_all, 3'b000);
      check("rst_gnt0", gnt0_all, 3'b000);
      check("rst_gnt1", gnt1_all, 3'b000);
      check("rst_data", g_inst[1].res_data, 64'd0);
      check("rst_id", g_inst[1].res_id, 1'b0);
      check("rst_tag", g_inst[1].res_tag, 5'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single ops and half select
      run_op(1'b0, 64'd3, 64'd5, 1'b0, 5'd7, 64'd15);
      run_op(1'b1, 64'h8000_0000_0000_0000, 64'd4, 1'b1, 5'd9, 64'd2);
      run_op(1'b0, '1, '1, 1'b1, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(1'b1, '1, '1, 1'b0, 5'd4, 64'd1);

      // Flush in the first BUSY cycle
      @(posedge clk); #1;
      drive_slot(1'b0, 64'd2, 64'd2, 1'b0, 5'd3);
      @(posedge clk); #1;
      req0 = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy_idle", busy_all, 3'b000);
      seen = rv_all;
      repeat (6) begin
         @(negedge clk);
         seen |= rv_all;
      end
      check("flush_no_result", seen, 3'b000);
      check("flush_data_kept", g_inst[1].res_data, 64'd1);
      check("flush_id_kept", g_inst[1].res_id, 1'b1);
      check("flush_tag_kept", g_inst[1].res_tag, 5'd4);

      // Flush in IDLE blocks grants
      @(posedge clk); #1;
      drive_slot(1'b1, 64'd6, 64'd6, 1'b0, 5'd1);
      flush = 1'b1;
      @(negedge clk);
      check("idle_flush_gnt1", gnt1_all, 3'b000);
      check("idle_flush_gnt0", gnt0_all, 3'b000);
      @(posedge clk); #1;
      req1 = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("idle_flush_no_accept", busy_all, 3'b000);

      // Reset mid-operation
      @(posedge clk); #1;
      drive_slot(1'b0, 64'd11, 64'd13, 1'b0, 5'd2);
      @(posedge clk); #1;
      req0 = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 3'b000;
      repeat (8) begin
         @(negedge clk);
         seen |= rv_all;
      end
      check("rst_mid_no_result", seen, 3'b000);
      @(posedge clk); #1;
      drive_slot(1'b0, 64'd1, 64'd1, 1'b0, 5'd0);
      drive_slot(1'b1, 64'd1, 64'd1, 1'b0, 5'd0);
      @(negedge clk);
      check("rst_mid_prio_gnt0", gnt0_all, 3'b111);
      check("rst_mid_prio_gnt1", gnt1_all, 3'b000);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      repeat (8) @(posedge clk);

      // Round-robin with both slots requesting from reset
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      drive_slot(1'b0, 64'd6, 64'd7, 1'b0, 5'd10);
      drive_slot(1'b1, 64'd8, 64'd9, 1'b0, 5'd11);
      for (int n = 0; n < 18; n++) begin
         @(negedge clk);
         if (gnt0_all[1] || gnt1_all[1]) begin
            gcyc.push_back(n);
            gslot.push_back(int'(gnt1_all[1]));
         end
         if (rv_all[1]) rid.push_back(int'(g_inst[1].res_id));
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      repeat (8) @(posedge clk);
      check("rr_grant_count", gslot.size(), 5);
      check("rr_first_cycle", (gcyc.size() > 0) ? gcyc[0] : -1, 0);
      for (int i = 0; i < 5; i++) begin
         if (i < gslot.size()) check($sformatf("rr_slot%0d", i), gslot[i], i % 2);
         if (i + 1 < gcyc.size()) check($sformatf("rr_gap%0d", i), gcyc[i+1] - gcyc[i], 4);
      end
      check("rr_result_count", rid.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < rid.size()) check($sformatf("rr_res_id%0d", i), rid[i], i % 2);

      // Random phase until 1000 results from the MC=2 instance
      nres = 0;
      cyc  = 0;
      while (nres < 1000 && cyc < 20000) begin
         @(posedge clk); #1;
         if (!req0) begin
            a0 = r64(); b0 = r64(); hi0 = 1'($urandom_range(1)); tag0 = 5'($urandom_range(31));
            req0 = ($urandom_range(3) != 0);
         end else if ($urandom_range(3) == 0) begin
            req0 = 1'b0;
         end
         if (!req1) begin
            a1 = r64(); b1 = r64(); hi1 = 1'($urandom_range(1)); tag1 = 5'($urandom_range(31));
            req1 = ($urandom_range(3) != 0);
         end else if ($urandom_range(3) == 0) begin
            req1 = 1'b0;
         end
         flush = ($urandom_range(15) == 0);
         rst   = ($urandom_range(499) == 0);
         @(negedge clk);
         if (rv_all[1]) nres++;
         cyc++;
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0; flush = 1'b0; rst = 1'b0;
      repeat (8) @(posedge clk);
      check("rand_result_count", nres >= 1000, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
